// File: rtl/dp_reg_stage.sv
// Pipeline delay register for LC-3 register-file indices (SR1, SR2, DR) with
// stall/flush control, a per-stage write-valid tag and per-stage hazard match flags.
module dp_reg_stage #(
    parameter int unsigned IDX_W = 3,
    parameter int unsigned DEPTH = 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             en,
    input  logic             flush,
    input  logic [IDX_W-1:0] sr1_in,
    input  logic [IDX_W-1:0] sr2_in,
    input  logic [IDX_W-1:0] dr_in,
    input  logic             dr_wr_in,
    output logic [IDX_W-1:0] sr1_out,
    output logic [IDX_W-1:0] sr2_out,
    output logic [IDX_W-1:0] dr_out,
    output logic             dr_wr_out,
    output logic [DEPTH-1:0] haz_sr1,
    output logic [DEPTH-1:0] haz_sr2
);

    generate
        if (DEPTH < 1 || DEPTH > 4) begin : g_bad_depth
            $error("dp_reg_stage: DEPTH must be in 1..4");
        end
    endgenerate

    logic [IDX_W-1:0] sr1_q [DEPTH];
    logic [IDX_W-1:0] sr2_q [DEPTH];
    logic [IDX_W-1:0] dr_q  [DEPTH];
    logic             wr_q  [DEPTH];

    // Stage chain: reset and flush clear everything, en shifts, otherwise hold.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int unsigned k = 0; k < DEPTH; k++) begin
                sr1_q[k] <= '0;
                sr2_q[k] <= '0;
                dr_q[k]  <= '0;
                wr_q[k]  <= 1'b0;
            end
        end else if (flush) begin
            for (int unsigned k = 0; k < DEPTH; k++) begin
                sr1_q[k] <= '0;
                sr2_q[k] <= '0;
                dr_q[k]  <= '0;
                wr_q[k]  <= 1'b0;
            end
        end else if (en) begin
            sr1_q[0] <= sr1_in;
            sr2_q[0] <= sr2_in;
            dr_q[0]  <= dr_in;
            wr_q[0]  <= dr_wr_in;
            for (int unsigned k = 1; k < DEPTH; k++) begin
                sr1_q[k] <= sr1_q[k-1];
                sr2_q[k] <= sr2_q[k-1];
                dr_q[k]  <= dr_q[k-1];
                wr_q[k]  <= wr_q[k-1];
            end
        end
    end

    assign sr1_out   = sr1_q[DEPTH-1];
    assign sr2_out   = sr2_q[DEPTH-1];
    assign dr_out    = dr_q[DEPTH-1];
    assign dr_wr_out = wr_q[DEPTH-1];

    // Hazard flags compare live source indices against each in-flight write.
    always_comb begin
        haz_sr1 = '0;
        haz_sr2 = '0;
        for (int unsigned k = 0; k < DEPTH; k++) begin
            haz_sr1[k] = wr_q[k] && (dr_q[k] == sr1_in);
            haz_sr2[k] = wr_q[k] && (dr_q[k] == sr2_in);
        end
    end

endmodule

// File: tb/tb_dp_reg_stage.sv
// Scoreboard bench for dp_reg_stage (DEPTH=3): a queue-based delay-line model
// produces expected outputs; a negedge monitor pops and compares.
module tb_dp_reg_stage;

    localparam int unsigned IDX_W = 3;
    localparam int unsigned DEPTH = 3;

    logic             clock = 1'b0;
    logic             reset = 1'b1;
    logic             en = 1'b0;
    logic             flush = 1'b0;
    logic [IDX_W-1:0] sr1_in = '0;
    logic [IDX_W-1:0] sr2_in = '0;
    logic [IDX_W-1:0] dr_in = '0;
    logic             dr_wr_in = 1'b0;
    logic [IDX_W-1:0] sr1_out;
    logic [IDX_W-1:0] sr2_out;
    logic [IDX_W-1:0] dr_out;
    logic             dr_wr_out;
    logic [DEPTH-1:0] haz_sr1;
    logic [DEPTH-1:0] haz_sr2;

    dp_reg_stage #(.IDX_W(IDX_W), .DEPTH(DEPTH)) dut (
        .clock     (clock),
        .reset     (reset),
        .en        (en),
        .flush     (flush),
        .sr1_in    (sr1_in),
        .sr2_in    (sr2_in),
        .dr_in     (dr_in),
        .dr_wr_in  (dr_wr_in),
        .sr1_out   (sr1_out),
        .sr2_out   (sr2_out),
        .dr_out    (dr_out),
        .dr_wr_out (dr_wr_out),
        .haz_sr1   (haz_sr1),
        .haz_sr2   (haz_sr2)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [IDX_W-1:0] sr1;
        logic [IDX_W-1:0] sr2;
        logic [IDX_W-1:0] dr;
        logic             wr;
    } ent_t;

    typedef struct {
        logic [IDX_W-1:0] sr1;
        logic [IDX_W-1:0] sr2;
        logic [IDX_W-1:0] dr;
        logic             wr;
        logic [DEPTH-1:0] h1;
        logic [DEPTH-1:0] h2;
    } exp_t;

    ent_t mdl[$];   // mdl[0] is the youngest instruction
    exp_t sb[$];
    int   checks = 0;
    int   failures = 0;

    function automatic void model_clear();
        ent_t z;
        z.sr1 = '0; z.sr2 = '0; z.dr = '0; z.wr = 1'b0;
        mdl.delete();
        for (int i = 0; i < int'(DEPTH); i++) mdl.push_back(z);
    endfunction

    initial model_clear();

    // Reference model advances on the same edge as the DUT.
    always @(posedge clock) begin
        if (reset || flush) begin
            model_clear();
        end else if (en) begin
            ent_t n;
            n.sr1 = sr1_in; n.sr2 = sr2_in; n.dr = dr_in; n.wr = dr_wr_in;
            mdl.push_front(n);
            void'(mdl.pop_back());
        end
    end

    function automatic exp_t expect_now();
        exp_t e;
        e.sr1 = mdl[DEPTH-1].sr1;
        e.sr2 = mdl[DEPTH-1].sr2;
        e.dr  = mdl[DEPTH-1].dr;
        e.wr  = mdl[DEPTH-1].wr;
        e.h1  = '0;
        e.h2  = '0;
        for (int k = 0; k < int'(DEPTH); k++) begin
            e.h1[k] = mdl[k].wr && (mdl[k].dr == sr1_in);
            e.h2[k] = mdl[k].wr && (mdl[k].dr == sr2_in);
        end
        return e;
    endfunction

    task automatic chk(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            failures++;
            $display("FAIL %s got=%0d want=%0d at %0t", name, got, want, $time);
        end
    endtask

    // Monitor: compare DUT against the oldest expectation every falling edge.
    always @(negedge clock) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            chk("sr1_out",   int'(sr1_out),   int'(e.sr1));
            chk("sr2_out",   int'(sr2_out),   int'(e.sr2));
            chk("dr_out",    int'(dr_out),    int'(e.dr));
            chk("dr_wr_out", int'(dr_wr_out), int'(e.wr));
            chk("haz_sr1",   int'(haz_sr1),   int'(e.h1));
            chk("haz_sr2",   int'(haz_sr2),   int'(e.h2));
        end
    end

    // One cycle of stimulus, driven just after a rising edge; rst pulses reset mid-cycle.
    task automatic step(input logic e, input logic f, input logic rst,
                        input int s1, input int s2, input int d, input logic w);
        en = e; flush = f;
        sr1_in = IDX_W'(s1); sr2_in = IDX_W'(s2); dr_in = IDX_W'(d); dr_wr_in = w;
        if (rst) begin
            reset = 1'b1;
            model_clear();
        end
        #0;
        sb.push_back(expect_now());
        @(negedge clock);
        #1;
        reset = 1'b0;
        @(posedge clock);
        #1;
    endtask

    initial begin
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        // latency chain and hazard on R0 / matching indices
        step(1, 0, 0, 2, 3, 1, 1);
        step(1, 0, 0, 3, 4, 2, 1);
        step(1, 0, 0, 4, 5, 3, 0);
        step(1, 0, 0, 5, 6, 4, 1);
        step(1, 0, 0, 0, 0, 0, 1);
        step(1, 0, 0, 0, 4, 0, 0);
        step(1, 0, 0, 0, 3, 5, 1);
        // async reset with loaded stages
        step(0, 0, 1, 5, 5, 5, 1);
        step(1, 0, 0, 2, 3, 4, 1);
        step(1, 0, 0, 4, 4, 6, 1);
        // stall while inputs change
        step(0, 0, 0, 6, 6, 7, 1);
        step(0, 0, 0, 7, 1, 2, 1);
        step(0, 0, 0, 4, 6, 3, 0);
        step(1, 0, 0, 7, 7, 7, 1);
        // flush overrides en
        step(1, 1, 0, 7, 7, 7, 1);
        step(1, 0, 0, 7, 7, 1, 1);
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 9) == 0),
                 ($urandom_range(0, 29) == 0),
                 int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                 int'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
        end
        @(negedge clock);
        #1;
        chk("sb_drained", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
